bf_input_responder: RTL and testbench
=====================================

// Module: bf_input_responder
// PURPOSE
//  Responder side of the machine's ',' (read-input) handshake. The controller raises
//  din_req (its DInChoose) while waiting for input. This block syncs and debounces the
//  user key, captures the 8-bit switch value on a fresh key press and raises inputDone.
//  It then drops inputDone and re-arms only after the key is released.
// PARAMETERS
//  DATA_W          8     width of switch data and din
//  DEBOUNCE_CYCLES 16    consecutive stable synced cycles before key_db changes (>=1)
//  HOLD_CYCLES     2     cycles inputDone stays high (>=1)
// PORTS
//  clk         in   1       system clock, all state on posedge
//  reset       in   1       asynchronous, active-high; clears all state
//  key_raw     in   1       asynchronous push button, 1 = pressed
//  sw          in   DATA_W  user switch value, sampled through 2-flop sync
//  din_req     in   1       controller waiting for input (',' command active)
//  inputDone   out  1       data valid / press accepted
//  din         out  DATA_W  captured input byte, stable from inputDone rise until next capture
//  busy        out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async, any time, incl. mid-handshake): state=IDLE, inputDone=0, din=0, busy=0,
//   sync flops=0, key_db=0, debounce/hold counters=0.
//  Sync: key_raw and sw each pass through 2 flops (key_s, sw_s). Latency 2 cycles.
//  Debounce: if key_s != key_db, cnt++; key_db<=key_s and cnt<=0 when cnt reaches
//   DEBOUNCE_CYCLES-1. If key_s == key_db, cnt<=0.
//   Counter width $clog2(DEBOUNCE_CYCLES+1).
//  press = key_db rising (registered edge detect, 1-cycle pulse).
//  FSM:
//   IDLE    : din_req=1 -> ARMED (even if key_db=1; a held key is not a press).
//   ARMED   : din_req=0 -> IDLE. press -> DONE: din<=sw_s, inputDone<=1, hold<=0.
//             If din_req=0 and press occur in the same cycle: din_req wins -> IDLE, no capture.
//   DONE    : inputDone=1; hold++. When hold==HOLD_CYCLES-1 -> RELEASE, inputDone<=0.
//             din_req is ignored here. The controller may already have left its wait state.
//   RELEASE : inputDone=0; key_db=0 -> IDLE. Key held indefinitely -> stays in RELEASE.
//  inputDone is registered and high for exactly HOLD_CYCLES cycles per press.
//  Exactly one inputDone pulse per accepted press; bounces shorter than
//   DEBOUNCE_CYCLES produce none.
//  din changes only on the ARMED->DONE transition; otherwise it holds its value.
//  Presses outside ARMED (IDLE/DONE/RELEASE) are discarded, never queued.
// TESTING
//  1 Reset: assert reset mid-DONE -> inputDone=0, din=0, busy=0 immediately (async).
//  2 Basic: DEBOUNCE=4, HOLD=2. din_req=1, sw=8'hA5, key 1 for 10 cycles
//    -> inputDone high 2 cycles, din=8'hA5, then RELEASE until key=0 debounced, then IDLE.
//  3 Bounce: key toggles every 2 cycles for 12 cycles while ARMED
//    -> no inputDone. Then steady 1 -> exactly one pulse.
//  4 Pre-held: key held 1 before din_req rises -> no inputDone.
//    Release then press -> one pulse with current sw.
//  5 Abort: din_req drops in ARMED before press -> IDLE, din unchanged.
//    Same-cycle drop+press -> no capture.
//  6 Hold: key held 100 cycles after capture -> single pulse, state RELEASE,
//    sw changes ignored, din stable.

Source files
------------

// File: rtl/bf_input_responder.sv
// bf_input_responder: responder side of the ',' read-input handshake.
// Synchronises and debounces the user key, captures the switch byte on a fresh
// press while the controller is waiting, pulses inputDone, then waits for key release.
`timescale 1ns/1ps
module bf_input_responder #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_raw,
    input  logic [DATA_W-1:0] sw,
    input  logic              din_req,
    output logic              inputDone,
    output logic [DATA_W-1:0] din,
    output logic              busy
);

    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StDone, StRelease} state_e;

    logic              r_key_s1;
    logic              r_key_s;
    logic [DATA_W-1:0] r_sw_s1;
    logic [DATA_W-1:0] r_sw_s;
    logic [CntW-1:0]   r_cnt;
    logic              r_key_db;
    logic              r_key_db_q;
    logic              w_press;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_done;
    logic              w_done_d;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] w_din_d;
    logic [HoldW-1:0]  r_hold;
    logic [HoldW-1:0]  w_hold_d;

    // Two-flop synchronisers for the asynchronous key and switch inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1 <= 1'b0;
            r_key_s  <= 1'b0;
            r_sw_s1  <= '0;
            r_sw_s   <= '0;
        end else begin
            r_key_s1 <= key_raw;
            r_key_s  <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s   <= r_sw_s1;
        end
    end

    // Debounce: key_db follows key_s only after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_key_db   <= 1'b0;
            r_key_db_q <= 1'b0;
        end else begin
            r_key_db_q <= r_key_db;
            if (r_key_s != r_key_db) begin
                if (r_cnt == CntLast) begin
                    r_key_db <= r_key_s;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Rising edge of the debounced key, one cycle wide.
    assign w_press = r_key_db & ~r_key_db_q;

    // Handshake state, capture register, done flag and hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
            r_din   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_done_d;
            r_din   <= w_din_d;
            r_hold  <= w_hold_d;
        end
    end

    // Next-state logic; a dropped request beats a simultaneous press.
    always_comb begin
        w_state_d = r_state;
        w_done_d  = r_done;
        w_din_d   = r_din;
        w_hold_d  = r_hold;
        unique case (r_state)
            StIdle: begin
                if (din_req) w_state_d = StArmed;
            end
            StArmed: begin
                if (!din_req) begin
                    w_state_d = StIdle;
                end else if (w_press) begin
                    w_state_d = StDone;
                    w_din_d   = r_sw_s;
                    w_done_d  = 1'b1;
                    w_hold_d  = '0;
                end
            end
            StDone: begin
                if (r_hold == HoldLast) begin
                    w_state_d = StRelease;
                    w_done_d  = 1'b0;
                    w_hold_d  = '0;
                end else begin
                    w_hold_d = r_hold + 1'b1;
                end
            end
            StRelease: begin
                w_done_d = 1'b0;
                if (!r_key_db) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs come straight from registers (busy decodes the state register).
    always_comb begin
        inputDone = r_done;
        din       = r_din;
        busy      = (r_state != StIdle);
    end

endmodule

// File: tb/tb_bf_input_responder.sv
// Directed self-checking bench for bf_input_responder (DEBOUNCE_CYCLES=4, HOLD_CYCLES=2).
`timescale 1ns/1ps
module tb_bf_input_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_raw;
    logic [7:0] sw;
    logic       din_req;
    logic       inputDone;
    logic [7:0] din;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0     = 0;
    logic done_prev = 1'b0;

    bf_input_responder #(
        .DATA_W         (8),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key_raw),
        .sw       (sw),
        .din_req  (din_req),
        .inputDone(inputDone),
        .din      (din),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Count inputDone rising edges, sampled away from the active edge.
    always @(negedge clk) begin
        if (inputDone === 1'b1 && done_prev !== 1'b1) pulses = pulses + 1;
        done_prev = inputDone;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (inputDone !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(inputDone), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; key_raw = 1'b0; sw = 8'h00; din_req = 1'b0;
        step(2);
        chk("rst_done", 32'(inputDone), 32'd0);
        chk("rst_din",  32'(din),       32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        reset = 1'b0;
        step(1);

        // Basic capture
        din_req = 1'b1; sw = 8'hA5;
        step(1);
        chk("arm_busy", 32'(busy), 32'd1);
        p0 = pulses;
        key_raw = 1'b1;
        wait_done("basic_done", 20);
        chk("basic_din", 32'(din), 32'hA5);
        step(1);
        chk("basic_hold2", 32'(inputDone), 32'd1);
        step(1);
        chk("basic_drop", 32'(inputDone), 32'd0);
        chk("basic_busy_rel", 32'(busy), 32'd1);
        step(4);
        chk("basic_rel_held", 32'(busy), 32'd1);
        chk("basic_one_pulse", 32'(pulses - p0), 32'd1);
        key_raw = 1'b0;
        wait_idle("basic_idle", 20);
        chk("basic_din_kept", 32'(din), 32'hA5);

        // Bounce shorter than the debounce window, then a steady press
        step(1);
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            key_raw = ~key_raw;
            step(2);
        end
        step(6);
        chk("bounce_none", 32'(pulses - p0), 32'd0);
        chk("bounce_armed", 32'(busy), 32'd1);
        sw = 8'h3C; key_raw = 1'b1;
        wait_done("bounce_done", 20);
        chk("bounce_din", 32'(din), 32'h3C);
        step(10);
        chk("bounce_one_pulse", 32'(pulses - p0), 32'd1);

        // Key already held when the request rises
        key_raw = 1'b0; din_req = 1'b0;
        step(20);
        chk("pre_idle", 32'(busy), 32'd0);
        key_raw = 1'b1;
        step(20);
        din_req = 1'b1; p0 = pulses;
        step(20);
        chk("pre_held_none", 32'(pulses - p0), 32'd0);
        chk("pre_held_armed", 32'(busy), 32'd1);
        chk("pre_held_din", 32'(din), 32'h3C);
        key_raw = 1'b0;
        step(20);
        sw = 8'h5A; key_raw = 1'b1;
        wait_done("pre_press", 20);
        chk("pre_din", 32'(din), 32'h5A);
        step(4);
        chk("pre_one_pulse", 32'(pulses - p0), 32'd1);

        // Abort before any press
        key_raw = 1'b0;
        step(20);
        chk("abort_armed", 32'(busy), 32'd1);
        sw = 8'h77; din_req = 1'b0;
        step(2);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_din", 32'(din), 32'h5A);
        p0 = pulses; key_raw = 1'b1;
        step(20);
        chk("abort_idle_press", 32'(pulses - p0), 32'd0);
        chk("abort_din2", 32'(din), 32'h5A);

        // Request drop lands on the cycle the debounced press is presented
        key_raw = 1'b0; din_req = 1'b1;
        step(20);
        chk("same_armed", 32'(busy), 32'd1);
        p0 = pulses; key_raw = 1'b1;
        step(6);
        din_req = 1'b0;
        step(10);
        chk("same_idle", 32'(busy), 32'd0);
        chk("same_none", 32'(pulses - p0), 32'd0);
        chk("same_din", 32'(din), 32'h5A);

        // Long hold after capture; switch activity must not disturb din
        key_raw = 1'b0;
        step(20);
        din_req = 1'b1;
        step(2);
        chk("hold_armed", 32'(busy), 32'd1);
        sw = 8'hC3; p0 = pulses; key_raw = 1'b1;
        wait_done("hold_done", 20);
        chk("hold_din", 32'(din), 32'hC3);
        for (int i = 0; i < 10; i++) begin
            sw = 8'($urandom);
            step(10);
        end
        chk("hold_one_pulse", 32'(pulses - p0), 32'd1);
        chk("hold_release", 32'(busy), 32'd1);
        chk("hold_done_low", 32'(inputDone), 32'd0);
        chk("hold_din_stable", 32'(din), 32'hC3);

        // Asynchronous reset in the middle of DONE
        key_raw = 1'b0;
        step(20);
        sw = 8'hE7; key_raw = 1'b1;
        wait_done("rst_mid_done", 20);
        chk("rst_mid_din", 32'(din), 32'hE7);
        #2 reset = 1'b1;
        #1;
        chk("async_done", 32'(inputDone), 32'd0);
        chk("async_din",  32'(din),       32'd0);
        chk("async_busy", 32'(busy),      32'd0);
        step(2);
        reset = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
